fuel_gauge: RTL and testbench

Consumer of the fuel-mode tick from the speed-dependent tick generator. Holds the player car's fuel level and decrements it by one on each tick. Applies refuel pickups and crash penalties, and flags low and empty fuel. Drives the two-digit fuel display and the low-fuel blink, and raises game-over to the game controller.

---
 rtl/fuel_gauge_pkg.sv | 23 ++
 rtl/fuel_gauge_if.sv | 37 +++
 rtl/fuel_gauge_bin2bcd99.sv | 24 ++
 rtl/fuel_gauge.sv | 121 ++++++++++++
 tb/tb_fuel_gauge.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/fuel_gauge_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package : fuel_pkg                                               |
// | Shared state encoding and default constants for the fuel gauge.  |
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
package fuel_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    LOW   = 2'd2,
    EMPTY = 2'd3
  } fuel_state_t;

  localparam int c_fuel_max     = 99;
  localparam int c_low_thresh   = 20;
  localparam int c_refuel_amt   = 25;
  localparam int c_crash_pen    = 10;
  localparam int c_blink_cycles = 12_500_000;

endpackage : fuel_pkg
`default_nettype wire

// File: rtl/fuel_gauge_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Interface : fuel_gauge_if                                        |
// | Game-side control pulses in, display/status signals out.         |
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
interface fuel_gauge_if;

  logic       start_game;
  logic       fuel_tick;
  logic       refuel;
  logic       crash;
  logic       pause;
  logic [6:0] fuel_level;
  logic [3:0] fuel_tens;
  logic [3:0] fuel_ones;
  logic       fuel_low;
  logic       low_blink;
  logic       fuel_empty;
  logic       game_over;

  // Game controller / tick generator side
  modport master (
    output start_game, fuel_tick, refuel, crash, pause,
    input  fuel_level, fuel_tens, fuel_ones, fuel_low, low_blink,
           fuel_empty, game_over
  );

  // Fuel gauge side
  modport slave (
    input  start_game, fuel_tick, refuel, crash, pause,
    output fuel_level, fuel_tens, fuel_ones, fuel_low, low_blink,
           fuel_empty, game_over
  );

endinterface : fuel_gauge_if
`default_nettype wire

// File: rtl/fuel_gauge_bin2bcd99.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : bin2bcd99                                               |
// | Combinational binary (0..99) to two-digit BCD conversion.       |
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
module bin2bcd99 (
  input  wire logic [6:0] bin_i,
  output logic      [3:0] tens_o,
  output logic      [3:0] ones_o
);

  // Tens digit is the largest multiple of ten not above the input;
  // ones is the remainder. Inputs above 99 are never presented.
  always_comb begin
    tens_o = 4'd0;
    for (int i = 1; i <= 9; i++) begin
      if (bin_i >= 7'(10 * i)) tens_o = 4'(i);
    end
    ones_o = 4'(bin_i - (7'(tens_o) * 7'd10));
  end

endmodule : bin2bcd99
`default_nettype wire

// File: rtl/fuel_gauge.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : fuel_gauge                                              |
// | Player fuel level: tick consumption, refuel/crash adjustment,    |
// | low/empty flags, BCD display digits, low-fuel blink, game over.  |
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
module fuel_gauge
  import fuel_pkg::*;
#(
  parameter int FUEL_MAX     = c_fuel_max,
  parameter int LOW_THRESH   = c_low_thresh,
  parameter int REFUEL_AMT   = c_refuel_amt,
  parameter int CRASH_PEN    = c_crash_pen,
  parameter int BLINK_CYCLES = c_blink_cycles
) (
  input  wire logic   clk,
  input  wire logic   resetN,
  fuel_gauge_if.slave bus
);

  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  fuel_state_t       state_q, state_d;
  logic [6:0]        level_q, level_d;
  logic [3:0]        tens_q, tens_d;
  logic [3:0]        ones_q, ones_d;
  logic              game_over_q, game_over_d;
  logic              blink_q;
  logic [BW-1:0]     blink_cnt_q;
  logic signed [8:0] level_sum_d;

  // Digits are converted from the next level so they land on the same
  // edge as the binary value.
  bin2bcd99 u_bcd (
    .bin_i  (level_d),
    .tens_o (tens_d),
    .ones_o (ones_d)
  );

  // Next level and next state: start_game dominates, otherwise RUN/LOW
  // apply the summed delta with a clamp; IDLE and EMPTY hold.
  always_comb begin
    state_d     = state_q;
    level_d     = level_q;
    game_over_d = 1'b0;
    level_sum_d = '0;
    if (bus.start_game) begin
      level_d = 7'(FUEL_MAX);
      state_d = RUN;
    end else if (state_q == RUN || state_q == LOW) begin
      level_sum_d = $signed({2'b00, level_q});
      if (bus.refuel)
        level_sum_d = level_sum_d + $signed(9'(REFUEL_AMT));
      if (bus.crash)
        level_sum_d = level_sum_d - $signed(9'(CRASH_PEN));
      if (bus.fuel_tick && !bus.pause)
        level_sum_d = level_sum_d - 9'sd1;

      if (level_sum_d[8])
        level_d = 7'd0;
      else if (level_sum_d > $signed(9'(FUEL_MAX)))
        level_d = 7'(FUEL_MAX);
      else
        level_d = level_sum_d[6:0];

      if (level_d == 7'd0) begin
        state_d     = EMPTY;
        game_over_d = 1'b1;
      end else if (level_d <= 7'(LOW_THRESH)) begin
        state_d = LOW;
      end else begin
        state_d = RUN;
      end
    end
  end

  // State, level, digits and game-over pulse registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= IDLE;
      level_q     <= 7'd0;
      tens_q      <= 4'd0;
      ones_q      <= 4'd0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      tens_q      <= tens_d;
      ones_q      <= ones_d;
      game_over_q <= game_over_d;
    end
  end

  // Blink runs only while staying in LOW; entry, exit and any other
  // state clear both the counter and the blink output.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else if (state_q != LOW || state_d != LOW) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else if (blink_cnt_q == BW'(BLINK_CYCLES - 1)) begin
      blink_cnt_q <= '0;
      blink_q     <= ~blink_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + 1'b1;
    end
  end

  assign bus.fuel_level = level_q;
  assign bus.fuel_tens  = tens_q;
  assign bus.fuel_ones  = ones_q;
  assign bus.fuel_low   = (state_q == LOW);
  assign bus.low_blink  = blink_q;
  assign bus.fuel_empty = (state_q == EMPTY);
  assign bus.game_over  = game_over_q;

endmodule : fuel_gauge
`default_nettype wire

// File: tb/tb_fuel_gauge.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : tb_fuel_gauge                                           |
// | Directed self-checking bench for fuel_gauge (BLINK_CYCLES = 4).  |
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
module tb_fuel_gauge;
  import fuel_pkg::*;

  logic clk;
  logic resetN;
  int   total = 0;
  int   bad   = 0;

  typedef struct {
    int lvl;
    bit low;
    bit blink;
    bit empty;
    bit go;
  } exp_t;

  exp_t sb[$];

  fuel_gauge_if bus ();

  fuel_gauge #(.BLINK_CYCLES(4)) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // One clock of stimulus; the expected outcome is queued when driven
  // and popped once the edge has produced the DUT's registered result.
  task automatic step(input bit sg, input bit tk, input bit rf, input bit cr,
                      input bit ps, input int lvl, input bit low, input bit bl,
                      input bit em, input bit go);
    exp_t e;
    @(negedge clk);
    bus.start_game = sg;
    bus.fuel_tick  = tk;
    bus.refuel     = rf;
    bus.crash      = cr;
    bus.pause      = ps;
    e = '{lvl: lvl, low: low, blink: bl, empty: em, go: go};
    sb.push_back(e);
    @(posedge clk);
    #1;
    chk("queue", sb.size(), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("level", bus.fuel_level, e.lvl);
      chk("tens",  bus.fuel_tens,  e.lvl / 10);
      chk("ones",  bus.fuel_ones,  e.lvl % 10);
      chk("low",   bus.fuel_low,   e.low);
      chk("blink", bus.low_blink,  e.blink);
      chk("empty", bus.fuel_empty, e.empty);
      chk("gover", bus.game_over,  e.go);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_level"}, bus.fuel_level, 0);
    chk({tag, "_tens"},  bus.fuel_tens,  0);
    chk({tag, "_ones"},  bus.fuel_ones,  0);
    chk({tag, "_low"},   bus.fuel_low,   0);
    chk({tag, "_blink"}, bus.low_blink,  0);
    chk({tag, "_empty"}, bus.fuel_empty, 0);
    chk({tag, "_gover"}, bus.game_over,  0);
    chk({tag, "_state"}, dut.state_q,    IDLE);
  endtask

  initial begin
    resetN         = 1'b0;
    bus.start_game = 1'b0;
    bus.fuel_tick  = 1'b0;
    bus.refuel     = 1'b0;
    bus.crash      = 1'b0;
    bus.pause      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("rst");
    @(negedge clk);
    resetN = 1'b1;

    // IDLE ignores consumption, pickups and crashes
    step(0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    chk("idle_state", dut.state_q, IDLE);

    // Start and three adjacent ticks
    step(1, 0, 0, 0, 0, 99, 0, 0, 0, 0);
    chk("start_state", dut.state_q, RUN);
    step(0, 1, 0, 0, 0, 98, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 97, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 96, 0, 0, 0, 0);

    // Crash + tick in the same cycle sum to -11
    step(0, 1, 0, 1, 0, 85, 0, 0, 0, 0);
    step(0, 1, 0, 1, 0, 74, 0, 0, 0, 0);
    step(0, 1, 0, 1, 0, 63, 0, 0, 0, 0);
    step(0, 1, 0, 1, 0, 52, 0, 0, 0, 0);
    step(0, 1, 0, 1, 0, 41, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 31, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 21, 0, 0, 0, 0);

    // 21 -> 20 enters LOW; blink rises 4 cycles later, falls after 8
    step(0, 1, 0, 0, 0, 20, 1, 0, 0, 0);
    chk("low_state", dut.state_q, LOW);
    step(0, 0, 0, 0, 0, 20, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 20, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 20, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 20, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0, 20, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0, 20, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0, 20, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0, 20, 1, 0, 0, 0);

    // Ticks within LOW keep the blink running
    step(0, 1, 0, 0, 0, 19, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 18, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 17, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 16, 1, 1, 0, 0);
    step(0, 1, 0, 0, 0, 15, 1, 1, 0, 0);

    // Refuel from 15 leaves LOW and drops blink on the same edge
    step(0, 0, 1, 0, 0, 40, 0, 0, 0, 0);
    chk("refuel_state", dut.state_q, RUN);
    step(0, 0, 1, 0, 0, 65, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 90, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 99, 0, 0, 0, 0);

    // Pause masks ticks but not crashes
    for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 1, 99, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 89, 0, 0, 0, 0);

    // Crash down through LOW to 9
    step(0, 0, 0, 1, 0, 79, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 69, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 59, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 49, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 39, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 29, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 19, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 9,  1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 8,  1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 7,  1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 6,  1, 1, 0, 0);
    step(0, 1, 0, 0, 0, 5,  1, 1, 0, 0);

    // 5 - 10 - 1 clamps to 0: EMPTY with a single game_over pulse
    step(0, 1, 0, 1, 0, 0, 0, 0, 1, 1);
    chk("empty_state", dut.state_q, EMPTY);
    step(0, 0, 1, 0, 0, 0, 0, 0, 1, 0);
    step(0, 1, 1, 1, 1, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);

    // Restart from EMPTY; other inputs ignored on the start cycle
    step(1, 1, 1, 1, 0, 99, 0, 0, 0, 0);
    chk("restart_state", dut.state_q, RUN);
    step(0, 1, 0, 0, 0, 98, 0, 0, 0, 0);

    // Asynchronous reset mid-game, between clock edges
    @(negedge clk);
    #2;
    resetN = 1'b0;
    #1;
    chk_zero("async");
    repeat (2) @(posedge clk);
    #1;
    chk("async_hold_gover", bus.game_over, 0);
    chk("async_hold_level", bus.fuel_level, 0);
    @(negedge clk);
    resetN = 1'b1;
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("post_rst_state", dut.state_q, IDLE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_fuel_gauge
`default_nettype wire
